// File: rtl/uart_pkg.sv
// Shared UART receive types and baud-timing helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  function automatic int bit_clks(input int clock_freq_hz, input int baud_rate);
    return clock_freq_hz / baud_rate;
  endfunction

  function automatic int half_clks(input int clock_freq_hz, input int baud_rate);
    return bit_clks(clock_freq_hz, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle: received word, valid/ready and error pulses.
interface uart_rx_if #(
    parameter int DataBitsSize = 8
);
    logic [DataBitsSize-1:0] rx_data;
    logic                    rx_valid;
    logic                    rx_ready;
    logic                    frame_err;
    logic                    parity_err;
    logic                    overrun;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO; head word is presented combinationally on dout.
module uart_rx_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW:0]    count;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && !empty;
    // A push while full is accepted only when a pop frees the head in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Depth; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (PtrW + 1)'(Depth));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];
endmodule

// File: rtl/uart_rx.sv
// UART receiver with optional even parity and valid/ready output storage.
// Define UART_RX_FIFO_EN for a 4-entry output FIFO instead of a single holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BaudRate     = 115200,
    parameter int ClockFreqHz  = 10000000,
    parameter int DataBitsSize = 8,
    parameter int ParityBit    = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx_sig,
    uart_rx_if.master bus
);
    localparam int BitClks  = bit_clks(ClockFreqHz, BaudRate);
    localparam int HalfClks = half_clks(ClockFreqHz, BaudRate);
    localparam int CntW     = $clog2(BitClks + 1);
    localparam int BitW     = $clog2(DataBitsSize + 1);

    uart_rx_state_e          state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [BitW-1:0]         bit_q, bit_d;
    logic [DataBitsSize-1:0] sh_q, sh_d;
    logic                    disc_q, disc_d;
    logic                    wait_q, wait_d;
    logic [1:0]              sync_q;
    logic                    rx_s;
    logic                    fe_d, pe_d, ov_d, deliver, transfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rx_sig};
    end
    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            disc_q  <= 1'b0;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            disc_q  <= disc_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        disc_d  = disc_q;
        wait_d  = wait_q;
        fe_d    = 1'b0;
        pe_d    = 1'b0;
        deliver = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                    bit_d   = '0;
                    disc_d  = 1'b0;
                    wait_d  = 1'b0;
                end
            end
            START: if (cnt_q == CntW'(HalfClks - 1)) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt_q == CntW'(BitClks - 1)) begin
                cnt_d = '0;
                sh_d  = {rx_s, sh_q[DataBitsSize-1:1]};
                bit_d = bit_q + 1'b1;
                if (bit_q == BitW'(DataBitsSize - 1)) begin
                    if (ParityBit != 0) state_d = PARITY;
                    else                state_d = STOP;
                end
            end
            PARITY: if (cnt_q == CntW'(BitClks - 1)) begin
                cnt_d   = '0;
                state_d = STOP;
                if (rx_s != (^sh_q)) begin
                    pe_d   = 1'b1;
                    disc_d = 1'b1;
                end
            end
            STOP: begin
                // After a framing error, linger here until the line returns high.
                if (wait_q) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                        wait_d  = 1'b0;
                    end
                end else if (cnt_q == CntW'(BitClks - 1)) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        deliver = !disc_q;
                        state_d = IDLE;
                    end else begin
                        fe_d   = 1'b1;
                        disc_d = 1'b1;
                        wait_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign transfer = bus.rx_valid && bus.rx_ready;

`ifdef UART_RX_FIFO_EN
    logic fifo_full, fifo_empty, fifo_push;

    assign fifo_push = deliver && (!fifo_full || transfer);
    assign ov_d      = deliver && fifo_full && !transfer;

    uart_rx_fifo #(
        .Width(DataBitsSize),
        .Depth(4)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (transfer),
        .din   (sh_q),
        .dout  (bus.rx_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    assign bus.rx_valid = !fifo_empty;
`else
    logic                    hold_valid;
    logic [DataBitsSize-1:0] hold_data;

    assign ov_d = deliver && hold_valid && !transfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (deliver && (!hold_valid || transfer)) begin
            hold_valid <= 1'b1;
            hold_data  <= sh_q;
        end else if (transfer) begin
            hold_valid <= 1'b0;
        end
    end
    assign bus.rx_valid = hold_valid;
    assign bus.rx_data  = hold_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.frame_err  <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.frame_err  <= fe_d;
            bus.parity_err <= pe_d;
            bus.overrun    <= ov_d;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a no-parity and an even-parity instance at default timing.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int BitT = 10_000_000 / 115_200;
`ifdef UART_RX_FIFO_EN
    localparam int Cap = 4;
`else
    localparam int Cap = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx0   = 1'b1;
    logic rx1   = 1'b1;
    int   ready_mode = 1;
    int   tests = 0;
    int   fails = 0;

    logic [7:0] expq0 [$];
    logic [7:0] expq1 [$];
    int exp_fe [2] = '{0, 0};
    int exp_pe [2] = '{0, 0};
    int exp_ov [2] = '{0, 0};
    int got_fe [2] = '{0, 0};
    int got_pe [2] = '{0, 0};
    int got_ov [2] = '{0, 0};
    bit         prev_hold [2] = '{0, 0};
    logic [7:0] prev_data [2];

    uart_rx_if #(.DataBitsSize(8)) bus0 ();
    uart_rx_if #(.DataBitsSize(8)) bus1 ();

    uart_rx #(.ParityBit(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .rx_sig(rx0), .bus(bus0.master));
    uart_rx #(.ParityBit(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .rx_sig(rx1), .bus(bus1.master));

    always #50 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        bus0.rx_ready = 1'b1;
        bus1.rx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus0.rx_ready = 1'b0;
                1:       bus0.rx_ready = 1'b1;
                default: bus0.rx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic mon_one(input int k, input logic v, input logic rdy, input logic [7:0] d,
                           input logic fe, input logic pe, input logic ov);
        logic [7:0] e;
        if (prev_hold[k]) begin
            chk("hold_valid", v, 1);
            chk("hold_data", d, prev_data[k]);
        end
        if (v && rdy) begin
            if ((k == 0 && expq0.size() == 0) || (k == 1 && expq1.size() == 0)) begin
                chk("unexpected_word", d, 32'hFFFF_FFFF);
            end else begin
                e = (k == 0) ? expq0.pop_front() : expq1.pop_front();
                chk("word", d, e);
            end
        end
        prev_hold[k] = v && !rdy;
        prev_data[k] = d;
        if (fe) got_fe[k]++;
        if (pe) got_pe[k]++;
        if (ov) got_ov[k]++;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_one(0, bus0.rx_valid, bus0.rx_ready, bus0.rx_data, bus0.frame_err, bus0.parity_err, bus0.overrun);
            mon_one(1, bus1.rx_valid, bus1.rx_ready, bus1.rx_data, bus1.frame_err, bus1.parity_err, bus1.overrun);
        end else begin
            prev_hold[0] = 1'b0;
            prev_hold[1] = 1'b0;
        end
    end

    task automatic drive(input int k, input logic b, input int cycles);
        if (k == 0) rx0 = b;
        else        rx1 = b;
        repeat (cycles) @(posedge clk);
    endtask

    task automatic check_reset_outputs();
        chk("rst_valid0", bus0.rx_valid, 0);
        chk("rst_data0", bus0.rx_data, 0);
        chk("rst_fe0", bus0.frame_err, 0);
        chk("rst_pe0", bus0.parity_err, 0);
        chk("rst_ov0", bus0.overrun, 0);
        chk("rst_valid1", bus1.rx_valid, 0);
        chk("rst_data1", bus1.rx_data, 0);
    endtask

    // Reference: decide the outcome from the frame contents, then drive the waveform.
    task automatic send_frame(input int k, input logic [7:0] data, input bit par_bad,
                              input int stop_low, input int rst_bit);
        int   nb;
        logic b;
        logic par;
        bit   ok;
        par = (^data) ^ par_bad;
        ok  = !(k == 1 && par_bad) && stop_low == 0 && rst_bit < 0;
        if (k == 1 && par_bad && rst_bit < 0) exp_pe[k]++;
        if (stop_low > 0 && rst_bit < 0) exp_fe[k]++;
        if (ok) begin
            if (((k == 0) ? expq0.size() : expq1.size()) >= Cap) exp_ov[k]++;
            else if (k == 0) expq0.push_back(data);
            else             expq1.push_back(data);
        end
        nb = (k == 1) ? 10 : 9;
        for (int i = 0; i < nb; i++) begin
            if (i == 0)      b = 1'b0;
            else if (i <= 8) b = data[i-1];
            else             b = par;
            if (rst_bit == i) begin
                drive(k, b, 30);
                @(negedge clk) rst_n = 1'b0;
                repeat (2) @(negedge clk);
                check_reset_outputs();
                drive(k, 1'b1, 2);
                @(negedge clk) rst_n = 1'b1;
                return;
            end
            drive(k, b, BitT);
        end
        if (stop_low > 0) drive(k, 1'b0, stop_low * BitT);
        drive(k, 1'b1, BitT + BitT + int'($urandom_range(0, BitT)));
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 4000 && (expq0.size() + expq1.size()) != 0; c++) @(posedge clk);
        chk(name, expq0.size() + expq1.size(), 0);
    endtask

    task automatic check_counts(input string name);
        for (int k = 0; k < 2; k++) begin
            chk({name, "_frame_err"}, got_fe[k], exp_fe[k]);
            chk({name, "_parity_err"}, got_pe[k], exp_pe[k]);
            chk({name, "_overrun"}, got_ov[k], exp_ov[k]);
        end
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (5) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        send_frame(0, 8'h41, 0, 0, -1);
        wait_drain("drain_41");
        check_counts("frame_41");

        drive(0, 1'b0, 20);
        drive(0, 1'b1, 2 * BitT);
        @(negedge clk);
        chk("glitch_valid", bus0.rx_valid, 0);
        check_counts("glitch");

        send_frame(0, 8'h55, 0, 2, -1);
        send_frame(0, 8'h0A, 0, 0, -1);
        wait_drain("drain_0a");
        check_counts("stop_err");

        ready_mode = 0;
        repeat (3) @(posedge clk);
        send_frame(0, 8'h01, 0, 0, -1);
        send_frame(0, 8'h02, 0, 0, -1);
        @(negedge clk);
        chk("stall_valid", bus0.rx_valid, 1);
        chk("stall_head", bus0.rx_data, expq0[0]);
        check_counts("stall");
        ready_mode = 1;
        wait_drain("drain_stall");

        send_frame(1, 8'h03, 1, 0, -1);
        send_frame(1, 8'h07, 0, 0, -1);
        wait_drain("drain_parity");
        check_counts("parity");

        send_frame(0, 8'h99, 0, 0, 5);
        drive(0, 1'b1, 2 * BitT);
        send_frame(0, 8'h7E, 0, 0, -1);
        wait_drain("drain_7e");
        check_counts("reset_mid");

        ready_mode = 2;
        for (int n = 0; n < 20; n++) begin
            k = int'($urandom_range(0, 1));
            send_frame(k, 8'($urandom), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0, -1);
        end
        ready_mode = 1;
        wait_drain("drain_random");
        check_counts("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BaudRate, default 115200, serial bit rate in bit/s.
REQ-002 SHALL have parameter ClockFreqHz, default 10000000, clk frequency in Hz.
REQ-003 SHALL have parameter DataBitsSize, default 8, data bits per frame (5..8).
REQ-004 SHALL have parameter ParityBit, default 0; 1 = one even-parity bit expected after the data bits.
REQ-005 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rx_sig  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port rx_data  output  DataBitsSize  received word, LSB = first data bit.
REQ-009 SHALL have port rx_valid  output  1  rx_data holds an unconsumed word.
REQ-010 SHALL have port rx_ready  input  1  consumer accepts rx_data when rx_valid is also high.
REQ-011 SHALL have ports frame_err, parity_err, overrun  output  1 each  single-cycle error pulses.

Function
REQ-012 SHALL pass rx_sig through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized line.
REQ-013 SHALL define BitClks = ClockFreqHz / BaudRate (integer division) and HalfClks = BitClks / 2.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, plus a default branch returning to IDLE.
REQ-015 SHALL, in IDLE, move to START and clear the bit counter when the synchronized line is 0.
REQ-016 SHALL, in START, sample after HalfClks cycles: line 0 -> DATA with the counter cleared; line 1 -> IDLE (glitch, nothing reported).
REQ-017 SHALL, in DATA, sample every BitClks cycles, shifting samples in LSB first; after DataBitsSize samples go to PARITY if ParityBit = 1, else STOP.
REQ-018 SHALL, in PARITY, sample after BitClks cycles; a mismatch against the XOR of the data bits pulses parity_err and discards the word; then go to STOP.
REQ-019 SHALL, in STOP, sample after BitClks cycles: 1 -> deliver the word (unless discarded) and go to IDLE; 0 -> pulse frame_err, discard the word, and stay in STOP until the line reads 1, then go to IDLE.
REQ-020 SHALL assert error pulses, and rx_valid for a newly delivered word, in the cycle after the sampling edge.
REQ-021 SHALL hold rx_valid and rx_data stable until a cycle where rx_valid and rx_ready are both high.
REQ-022 SHALL, when a word is delivered while storage is full and no transfer occurs in the same cycle, pulse overrun, drop the new word and keep the stored data.
REQ-023 SHALL treat a delivery coinciding with a transfer at full as legal: no overrun.
REQ-024 SHALL keep receiving regardless of rx_ready.

Reset
REQ-025 SHALL, on rst_n low, force IDLE, clear counters, shift register and storage, and drive rx_valid=0, rx_data=0, frame_err=0, parity_err=0, overrun=0.
REQ-026 SHALL, on reset mid-frame, abandon the frame; after release the next falling edge is treated as a new start bit.

Configuration
REQ-027 SHALL use macro UART_RX_FIFO_EN: defined -> storage is a 4-entry FIFO, rx_data/rx_valid show its head, overrun only when 4 words are held.
REQ-028 SHALL, without UART_RX_FIFO_EN, use a single holding register, with overrun whenever rx_valid is high and no transfer occurs in that cycle.

Structure
REQ-029 SHALL place the uart_rx_state_e enum and the BitClks/HalfClks computation in shared package uart_pkg.
REQ-030 SHALL implement the FIFO as sub-module uart_rx_fifo (Depth parameter, push/pop/full/empty), instantiated only under UART_RX_FIFO_EN.

Verification
All scenarios use defaults (BitClks = 86).
REQ-031 SHALL cover: frame 0x41, 86 clk/bit, rx_ready=1 -> rx_valid for 1 cycle with rx_data=0x41, no error pulses.
REQ-032 SHALL cover: a 20-cycle low glitch on rx_sig -> return to IDLE with no rx_valid and no error pulses.
REQ-033 SHALL cover: frame 0x55 with stop bit held 0 for 2 bit times -> one frame_err pulse, no rx_valid, next frame 0x0A received correctly.
REQ-034 SHALL cover: rx_ready=0 and frames 0x01, 0x02 -> without macro: overrun after 0x02 and rx_data=0x01; with macro: no overrun, words popped in order 0x01, 0x02.
REQ-035 SHALL cover: ParityBit=1, frame 0x03 with parity bit 1 -> parity_err pulse and no rx_valid.
REQ-036 SHALL cover: rst_n pulsed low during data bit 4 -> outputs 0, and the frame 0x7E sent afterwards is received correctly.
